// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, PC step, reset vector.
// Imported by the fetch unit and its watchdog.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } if_state_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_watchdog.sv
// Fetch stall watchdog: counts unacknowledged request cycles and
// raises a sticky error once the limit is reached.
module if_watchdog #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic err
);

  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] CNT_MAX = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_n;
  logic         err_q;

  always_comb begin
    cnt_n = cnt_q;
    if (ack) begin
      cnt_n = '0;
    end else if (active && cnt_q != CNT_MAX) begin
      cnt_n = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      if (cnt_n == CNT_MAX) err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/REQ/HOLD/FLUSH FSM, registered outputs.
// Optional stall watchdog enabled by defining IF_TIMEOUT_EN.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_pc,
  input  logic        write_ir,
  input  logic        pc_load,
  input  logic [31:0] pc_new,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IR,
  output logic        W_IR_valid,
  output logic [31:0] PC,
  output logic        fetch_err
);

  localparam logic [31:0] RST_PC = word_align(RESET_PC);

  if_state_t   state_q, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] ir_q, ir_n;
  logic        vld_q, vld_n;
  logic        req_q, req_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] pc_tgt;

  assign pc_tgt = word_align(pc_new);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RST_PC;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      ir_q    <= ir_n;
      vld_q   <= vld_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    ir_n    = ir_q;
    vld_n   = vld_q;
    req_n   = req_q;
    addr_n  = addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_n  = pc_tgt;
          vld_n = 1'b0;
        end
        if (write_pc) begin
          state_n = S_REQ;
          req_n   = 1'b1;
          addr_n  = pc_n;
        end
      end
      S_REQ: begin
        if (pc_load) begin
          pc_n  = pc_tgt;
          vld_n = 1'b0;
          if (imem_ack) begin
            state_n = write_pc ? S_REQ : S_IDLE;
            req_n   = write_pc;
            if (write_pc) addr_n = pc_tgt;
          end else begin
            // old request stays on the bus until it drains
            state_n = S_FLUSH;
          end
        end else if (imem_ack) begin
          ir_n    = imem_rdata;
          vld_n   = 1'b1;
          req_n   = 1'b0;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_load || write_ir) begin
          pc_n    = pc_load ? pc_tgt : pc_q + PC_STEP;
          vld_n   = 1'b0;
          state_n = write_pc ? S_REQ : S_IDLE;
          req_n   = write_pc;
          if (write_pc) addr_n = pc_n;
        end
      end
      S_FLUSH: begin
        if (pc_load) pc_n = pc_tgt;
        if (imem_ack) begin
          state_n = S_REQ;
          addr_n  = pc_n;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign IR         = ir_q;
  assign W_IR_valid = vld_q;
  assign PC         = pc_q;

`ifdef IF_TIMEOUT_EN
  logic wd_active;
  logic wd_ack;

  assign wd_active = (state_q == S_REQ) || (state_q == S_FLUSH);
  assign wd_ack    = wd_active && imem_ack;

  if_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .active (wd_active),
    .ack    (wd_ack),
    .err    (fetch_err)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; checks sampled 1 time unit after
// each rising edge. Define IF_TIMEOUT_EN to exercise the watchdog.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_pc;
  logic        write_ir;
  logic        pc_load;
  logic [31:0] pc_new;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic [31:0] PC;
  logic        fetch_err;

  int vecs = 0;
  int errs = 0;

  instr_fetch #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write_pc   (write_pc),
    .write_ir   (write_ir),
    .pc_load    (pc_load),
    .pc_new     (pc_new),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .IR         (IR),
    .W_IR_valid (W_IR_valid),
    .PC         (PC),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    write_pc = 1'b0;
    write_ir = 1'b0;
    pc_load = 1'b0;
    pc_new = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    tick();
    tick();
    chk("rst_pc", PC, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_vld", {31'd0, W_IR_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);

    // fast fetch: ack in first REQ cycle
    rst = 1'b0;
    write_pc = 1'b1;
    tick();
    chk("f1_req", {31'd0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'h0);
    chk("f1_vld0", {31'd0, W_IR_valid}, 32'd0);
    write_pc = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hE081_2003;
    tick();
    imem_ack = 1'b0;
    chk("f1_vld", {31'd0, W_IR_valid}, 32'd1);
    chk("f1_ir", IR, 32'hE081_2003);
    chk("f1_pc", PC, 32'h0);
    chk("f1_reqlo", {31'd0, imem_req}, 32'd0);
    tick();
    chk("hold_ir", IR, 32'hE081_2003);
    chk("hold_pc", PC, 32'h0);

    // consume and fetch next with a 5-cycle ack delay
    write_ir = 1'b1;
    write_pc = 1'b1;
    tick();
    write_ir = 1'b0;
    write_pc = 1'b0;
    chk("c1_pc", PC, 32'h4);
    chk("c1_vld", {31'd0, W_IR_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("dly_req", {31'd0, imem_req}, 32'd1);
      chk("dly_addr", imem_addr, 32'h4);
      tick();
    end
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    chk("f2_vld", {31'd0, W_IR_valid}, 32'd1);
    chk("f2_ir", IR, 32'h0000_0013);
    chk("f2_pc", PC, 32'h4);

    // redirect while a request is pending
    write_ir = 1'b1;
    write_pc = 1'b1;
    tick();
    write_ir = 1'b0;
    chk("c2_pc", PC, 32'h8);
    chk("c2_addr", imem_addr, 32'h8);
    pc_load = 1'b1;
    pc_new = 32'h0000_0103;
    tick();
    pc_load = 1'b0;
    chk("fl_pc", PC, 32'h100);
    chk("fl_req", {31'd0, imem_req}, 32'd1);
    chk("fl_addr", imem_addr, 32'h8);
    tick();
    chk("fl_addr2", imem_addr, 32'h8);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("fl_vld", {31'd0, W_IR_valid}, 32'd0);
    chk("fl_ir", IR, 32'h0000_0013);
    chk("fl_newaddr", imem_addr, 32'h100);
    chk("fl_newreq", {31'd0, imem_req}, 32'd1);
    imem_rdata = 32'h0010_0093;
    tick();
    imem_ack = 1'b0;
    chk("f3_ir", IR, 32'h0010_0093);
    chk("f3_pc", PC, 32'h100);

    // wrap at top of address space
    pc_load = 1'b1;
    pc_new = 32'hFFFF_FFFC;
    tick();
    pc_load = 1'b0;
    chk("w_pc", PC, 32'hFFFF_FFFC);
    chk("w_addr", imem_addr, 32'hFFFF_FFFC);
    chk("w_vld", {31'd0, W_IR_valid}, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    chk("w_ir", IR, 32'h1111_1111);
    write_ir = 1'b1;
    tick();
    write_ir = 1'b0;
    chk("w_wrap", PC, 32'h0);
    chk("w_wrapaddr", imem_addr, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h2222_2222;
    write_pc = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("w_ir2", IR, 32'h2222_2222);

    // redirect beats consume in HOLD
    pc_load = 1'b1;
    pc_new = 32'h0000_0200;
    write_ir = 1'b1;
    tick();
    pc_load = 1'b0;
    write_ir = 1'b0;
    chk("pri_pc", PC, 32'h200);
    chk("pri_vld", {31'd0, W_IR_valid}, 32'd0);
    chk("pri_req", {31'd0, imem_req}, 32'd0);

    // redirect with ack in REQ discards data
    write_pc = 1'b1;
    tick();
    chk("ra_addr", imem_addr, 32'h200);
    write_pc = 1'b0;
    pc_load = 1'b1;
    pc_new = 32'h0000_0300;
    imem_ack = 1'b1;
    imem_rdata = 32'h3333_3333;
    tick();
    pc_load = 1'b0;
    chk("ra_pc", PC, 32'h300);
    chk("ra_req", {31'd0, imem_req}, 32'd0);
    chk("ra_ir", IR, 32'h2222_2222);

    // stray ack in IDLE ignored
    tick();
    imem_ack = 1'b0;
    chk("st_vld", {31'd0, W_IR_valid}, 32'd0);
    chk("st_ir", IR, 32'h2222_2222);

    // reset mid-request, then stale ack
    write_pc = 1'b1;
    tick();
    chk("rm_req", {31'd0, imem_req}, 32'd1);
    chk("rm_addr", imem_addr, 32'h300);
    rst = 1'b1;
    write_pc = 1'b0;
    tick();
    rst = 1'b0;
    chk("rm_reqlo", {31'd0, imem_req}, 32'd0);
    chk("rm_pc", PC, 32'h0);
    imem_ack = 1'b1;
    imem_rdata = 32'h4444_4444;
    tick();
    imem_ack = 1'b0;
    chk("rm_stale_vld", {31'd0, W_IR_valid}, 32'd0);
    chk("rm_stale_ir", IR, 32'h0);

    // stall with no ack
    write_pc = 1'b1;
    tick();
    write_pc = 1'b0;
`ifdef IF_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    chk("to_pre", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("to_set", {31'd0, fetch_err}, 32'd1);
    chk("to_wait", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_5555;
    tick();
    imem_ack = 1'b0;
    chk("to_ack_ir", IR, 32'h5555_5555);
    chk("to_sticky", {31'd0, fetch_err}, 32'd1);
    tick();
    chk("to_sticky2", {31'd0, fetch_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("to_clr", {31'd0, fetch_err}, 32'd0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("no_to_err", {31'd0, fetch_err}, 32'd0);
    chk("no_to_req", {31'd0, imem_req}, 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded by reset (bits [1:0] forced 0).
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL be the stall limit in cycles; used only when IF_TIMEOUT_EN is defined.
REQ-003 Port clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 Port rst  in  1  SHALL be the synchronous active-high reset.
REQ-005 Port write_pc  in  1  SHALL be the control FSM's fetch enable; a new memory request is issued only while it is high.
REQ-006 Port write_ir  in  1  SHALL be the control FSM's consume strobe; with W_IR_valid high it accepts IR.
REQ-007 Port pc_load  in  1  SHALL be the redirect request (branch/exception).
REQ-008 Port pc_new  in  32  SHALL be the redirect target; bits [1:0] ignored.
REQ-009 Port imem_req  out  1  SHALL be the instruction memory read request.
REQ-010 Port imem_addr  out  32  SHALL be the word-aligned read address.
REQ-011 Port imem_ack  in  1  SHALL be the memory response strobe; imem_rdata is valid in the same cycle.
REQ-012 Port imem_rdata  in  32  SHALL be the returned instruction word.
REQ-013 Port IR  out  32  SHALL be the fetched instruction presented to the control FSM.
REQ-014 Port W_IR_valid  out  1  SHALL indicate IR holds an unconsumed instruction.
REQ-015 Port PC  out  32  SHALL be the address of the instruction in IR (or of the next fetch when IR is empty).
REQ-016 Port fetch_err  out  1  SHALL be the sticky fetch-timeout flag.

Function
REQ-017 States SHALL be IDLE, REQ, HOLD, FLUSH; all outputs registered.
REQ-018 IDLE: write_pc -> REQ next cycle; else stay.
REQ-019 REQ: imem_req=1, imem_addr=PC, held stable until imem_ack; on ack IR<=imem_rdata, W_IR_valid=1 next cycle, -> HOLD.
REQ-020 HOLD: write_ir -> W_IR_valid=0, PC<=PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), next state REQ if write_pc else IDLE; no write_ir -> IR, PC held.
REQ-021 Minimum fetch latency SHALL be 2 cycles from entering REQ with same-cycle ack to W_IR_valid high.
REQ-022 pc_load SHALL have priority over every other event: PC<=pc_new&~3, W_IR_valid<=0 next cycle.
REQ-023 pc_load in REQ without ack -> FLUSH; imem_req and imem_addr stay at the old request until ack, data discarded, then -> REQ at new PC.
REQ-024 pc_load in REQ with ack -> returned data discarded, next state REQ if write_pc else IDLE.
REQ-025 pc_load in FLUSH SHALL only update PC; FLUSH continues.
REQ-026 pc_load with write_ir in HOLD: redirect wins, no PC+4.
REQ-027 imem_ack outside REQ/FLUSH SHALL be ignored.

Reset
REQ-028 On rst: state IDLE, PC=RESET_PC, IR=0, W_IR_valid=0, imem_req=0, imem_addr=0, fetch_err=0, stall counter=0.
REQ-029 rst mid-request SHALL drop imem_req next cycle; a later stale ack is ignored per REQ-027.

Configuration
REQ-030 Macro IF_TIMEOUT_EN defined: counter increments each REQ/FLUSH cycle without ack, clears on ack; reaching TIMEOUT_CYCLES sets fetch_err until rst; fetch keeps waiting.
REQ-031 IF_TIMEOUT_EN undefined: no counter, fetch_err tied 0.

Structure
REQ-032 State encodings, PC_STEP=4 and RESET_PC default SHALL live in shared package cpu_pkg.
REQ-033 Optional sub-module if_watchdog SHALL contain the timeout counter; instantiated only under IF_TIMEOUT_EN.

Verification
REQ-034 Reset, write_pc=1, ack on first REQ cycle with rdata=32'hE0812003 -> W_IR_valid 2 cycles later, IR=32'hE0812003, PC=0.
REQ-035 Ack delayed 5 cycles -> imem_req and imem_addr stable all 5 cycles; write_ir then gives PC=4.
REQ-036 pc_load, pc_new=32'h0000_0103, during pending REQ -> FLUSH, old data discarded, next imem_addr=32'h0000_0100.
REQ-037 PC=32'hFFFF_FFFC, consume -> PC=0; simultaneous pc_load and write_ir in HOLD -> PC=pc_new.
REQ-038 IF_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> fetch_err high after 16 REQ cycles, stays high after ack, clears only on rst.
